// File: rtl/controller_modulo.sv
// Control FSM for the repeated compare/subtract modulo datapath (ergebnis = Zahl1 mod Zahl2).
// Optional iteration watchdog enabled by defining MOD_WATCHDOG_EN.
module controller_modulo #(
  parameter int unsigned ALU_LAT  = 2,
  parameter logic [2:0]  ALU_CMP  = 3'd2,
  parameter logic [2:0]  ALU_SUB  = 3'd1
`ifdef MOD_WATCHDOG_EN
  ,
  parameter logic [15:0] MAX_ITER = 16'hFFFF
`endif
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       valid_i,
  output logic [2:0] alu_mode_o,
  output logic       wren_update_Zahlen_o,
  output logic       wren_Zahl1_to_erg_o,
  output logic       wren_res_to_erg_o,
  output logic       wren_term_erg_o,
  output logic       erg_to_alu_a_o,
  output logic       Zahl2_to_alu_b_o,
  output logic       check_for_termination_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_INIT  = 4'd2;
  localparam logic [3:0] S_CMP   = 4'd3;
  localparam logic [3:0] S_TERM  = 4'd4;
  localparam logic [3:0] S_CHECK = 4'd5;
  localparam logic [3:0] S_SUB   = 4'd6;
  localparam logic [3:0] S_WB    = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_ERROR = 4'd9;

  localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

  logic [3:0] state_q, state_d;
  logic [2:0] wait_q, wait_d;

  logic [2:0] alu_mode_q, alu_mode_d;
  logic       upd_q, upd_d;
  logic       z1erg_q, z1erg_d;
  logic       reserg_q, reserg_d;
  logic       term_q, term_d;
  logic       sela_q, sela_d;
  logic       selb_q, selb_d;
  logic       chk_q, chk_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

`ifdef MOD_WATCHDOG_EN
  logic [15:0] iter_q, iter_d;
  logic        err_q, err_d;
`endif

  // Next-state logic; the wait counter times the ALU latency inside CMP and SUB.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
`ifdef MOD_WATCHDOG_EN
    iter_d  = iter_q;
`endif
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_INIT;
`ifdef MOD_WATCHDOG_EN
        iter_d  = '0;
`endif
      end
      S_INIT:  state_d = S_CMP;
      S_CMP: begin
        if (wait_q == LAT_LAST) state_d = S_TERM;
        else                    wait_d  = wait_q + 3'd1;
      end
      S_TERM:  state_d = S_CHECK;
      S_CHECK: state_d = valid_i ? S_DONE : S_SUB;
      S_SUB: begin
        if (wait_q == LAT_LAST) state_d = S_WB;
        else                    wait_d  = wait_q + 3'd1;
      end
      S_WB: begin
`ifdef MOD_WATCHDOG_EN
        iter_d  = iter_q + 16'd1;
        state_d = (iter_q + 16'd1 == MAX_ITER) ? S_ERROR : S_CMP;
`else
        state_d = S_CMP;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    alu_mode_d = 3'd0;
    upd_d      = 1'b0;
    z1erg_d    = 1'b0;
    reserg_d   = 1'b0;
    term_d     = 1'b0;
    sela_d     = 1'b0;
    selb_d     = 1'b0;
    chk_d      = 1'b0;
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
`ifdef MOD_WATCHDOG_EN
    err_d      = 1'b0;
`endif
    case (state_d)
      S_LOAD:  upd_d   = 1'b1;
      S_INIT:  z1erg_d = 1'b1;
      S_CMP: begin
        alu_mode_d = ALU_CMP;
        sela_d     = 1'b1;
        selb_d     = 1'b1;
      end
      S_TERM: begin
        alu_mode_d = ALU_CMP;
        sela_d     = 1'b1;
        selb_d     = 1'b1;
        term_d     = 1'b1;
      end
      S_CHECK: chk_d = 1'b1;
      S_SUB: begin
        alu_mode_d = ALU_SUB;
        sela_d     = 1'b1;
        selb_d     = 1'b1;
      end
      S_WB: begin
        alu_mode_d = ALU_SUB;
        sela_d     = 1'b1;
        selb_d     = 1'b1;
        reserg_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
`ifdef MOD_WATCHDOG_EN
      S_ERROR: err_d  = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      alu_mode_q <= '0;
      upd_q      <= 1'b0;
      z1erg_q    <= 1'b0;
      reserg_q   <= 1'b0;
      term_q     <= 1'b0;
      sela_q     <= 1'b0;
      selb_q     <= 1'b0;
      chk_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      alu_mode_q <= alu_mode_d;
      upd_q      <= upd_d;
      z1erg_q    <= z1erg_d;
      reserg_q   <= reserg_d;
      term_q     <= term_d;
      sela_q     <= sela_d;
      selb_q     <= selb_d;
      chk_q      <= chk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef MOD_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      iter_q <= '0;
      err_q  <= 1'b0;
    end else begin
      iter_q <= iter_d;
      err_q  <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign alu_mode_o              = alu_mode_q;
  assign wren_update_Zahlen_o    = upd_q;
  assign wren_Zahl1_to_erg_o     = z1erg_q;
  assign wren_res_to_erg_o       = reserg_q;
  assign wren_term_erg_o         = term_q;
  assign erg_to_alu_a_o          = sela_q;
  assign Zahl2_to_alu_b_o        = selb_q;
  assign check_for_termination_o = chk_q;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;

endmodule
